stream_align: RTL and testbench

- Joins NUM_CH independent pixel streams (e.g. left/right census windows) on one clock. It emits a single aligned tuple only when every channel's head sample carries the same (x,y) coordinate.
- Replaces the bare AND of per-channel valids ahead of correlate.
- Per-channel FIFOs absorb skew between channels. Stale or orphaned samples are discarded.
- Output uses a valid/ready handshake toward the consumer.

---
 rtl/stream_align.sv | 208 ++++++++++++++++++++
 tb/tb_stream_align.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_align.sv
// stream_align: joins NUM_CH coordinate-tagged pixel streams.
// Each channel has its own FIFO that absorbs skew between channels.
// The FIFO heads are compared by their {y,x} key, and stale or orphaned
// heads are dropped. When every head carries the same key, one aligned
// tuple is registered toward a valid/ready consumer.
//
// Parameters:
//   NUM_CH     - number of input streams, 2..4
//   DATA_W     - payload bits per sample per channel
//   FIFO_DEPTH - entries per channel FIFO, power of two, >= 4
//   CNT_W      - width of the saturating drop counter
module stream_align #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 72,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_val,
  input  logic [NUM_CH*10-1:0]     in_x,
  input  logic [NUM_CH*10-1:0]     in_y,
  input  logic [NUM_CH-1:0]        is_in_val,
  input  logic                     out_rdy,
  output logic [NUM_CH*DATA_W-1:0] out_val,
  output logic [9:0]               out_x,
  output logic [9:0]               out_y,
  output logic                     is_out_val,
  output logic [NUM_CH-1:0]        overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int KEY_W = 20;
  localparam int ENT_W = DATA_W + KEY_W;
  localparam int NCW   = $clog2(NUM_CH + 1);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // FIFO storage: each entry is {y, x, data}, so the key sits just above the payload
  logic [ENT_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  // vis_ptr_q is the write pointer as the read side sees it, one cycle late.
  // A new entry therefore reaches the head compare on the cycle after it is written.
  logic [NUM_CH-1:0][AW:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_CH-1:0][AW:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_CH-1:0][AW:0] vis_ptr_q;

  logic [NUM_CH-1:0]        ovf_q, ovf_d;
  logic [CNT_W-1:0]         drop_q, drop_d;
  logic                     out_vld_q, out_vld_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  logic [9:0]               out_x_q, out_x_d;
  logic [9:0]               out_y_q, out_y_d;

  // Head view of every FIFO
  logic [NUM_CH-1:0][ENT_W-1:0] head_ent;
  logic [NUM_CH-1:0][KEY_W-1:0] head_key;
  logic [NUM_CH-1:0]            head_empty;
  logic [NUM_CH-1:0]            fifo_full;

  // Alignment decision
  logic              all_valid;
  logic              all_equal;
  logic              zero_seen;
  logic              nz_seen;
  logic              frame_start;
  logic              discard;
  logic              match;
  logic              load;
  logic [KEY_W-1:0]  max_key;
  logic [NUM_CH-1:0] drop_pop;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] push_ok;
  logic [NCW-1:0]    drop_n;
  logic [CNT_W:0]    drop_sum;

  // Decode each FIFO's head entry, key, empty flag and full flag
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    //       logic, so no path through the block leaves a value unassigned.
    //       An unassigned path would infer a latch.
    head_ent   = '0;
    head_key   = '0;
    head_empty = '0;
    fifo_full  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      head_ent[c]   = mem_q[c][rd_ptr_q[c][AW-1:0]];
      head_key[c]   = head_ent[c][DATA_W +: KEY_W];
      head_empty[c] = (rd_ptr_q[c] == vis_ptr_q[c]);
      fifo_full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                      (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
    end
  end

  // Compare head keys and decide between frame-start flush, discard and match
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so that later lines see the
    //       values just computed. Clocked blocks use '<=' only.
    all_valid = 1'b1;
    all_equal = 1'b1;
    zero_seen = 1'b0;
    nz_seen   = 1'b0;
    max_key   = '0;
    drop_pop  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      all_valid = all_valid & ~head_empty[c];
      zero_seen = zero_seen | (~head_empty[c] & (head_key[c] == '0));
      nz_seen   = nz_seen   | (~head_empty[c] & (head_key[c] != '0));
      if (head_key[c] != head_key[0]) all_equal = 1'b0;
      if (!head_empty[c] && head_key[c] > max_key) max_key = head_key[c];
    end
    // A zero key next to a non-zero key means a new frame has begun on some
    // channel. The non-zero heads belong to the previous frame.
    frame_start = zero_seen & nz_seen;
    discard     = ~frame_start & all_valid & ~all_equal;
    match       = all_valid & all_equal;
    load        = match & (~out_vld_q | out_rdy);
    for (int c = 0; c < NUM_CH; c++) begin
      if (frame_start) drop_pop[c] = ~head_empty[c] & (head_key[c] != '0);
      else if (discard) drop_pop[c] = (head_key[c] < max_key);
    end
  end

  // FIFO pointer updates, overflow flags and the saturating drop counter
  always_comb begin
    pop      = '0;
    push_ok  = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    drop_n   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]     = drop_pop[c] | load;
      // A full FIFO still takes the write when its head leaves this cycle.
      push_ok[c] = is_in_val[c] & (~fifo_full[c] | pop[c]);
      if (push_ok[c]) wr_ptr_d[c] = wr_ptr_q[c] + PTR_ONE;
      if (pop[c])     rd_ptr_d[c] = rd_ptr_q[c] + PTR_ONE;
      if (is_in_val[c] && fifo_full[c] && !pop[c]) ovf_d[c] = 1'b1;
      if (drop_pop[c]) drop_n = drop_n + NCW'(1);
    end
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_n);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  // Output register: load on match, hold under backpressure, clear when drained
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_x_d   = head_key[0][9:0];
      out_y_d   = head_key[0][19:10];
      for (int c = 0; c < NUM_CH; c++) begin
        out_data_d[c*DATA_W +: DATA_W] = head_ent[c][DATA_W-1:0];
      end
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  // Control state: pointers, flags, counter and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vis_ptr_q  <= '0;
      ovf_q      <= '0;
      drop_q     <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vis_ptr_q  <= wr_ptr_q;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
    end
  end

  // FIFO storage write port
  // NOTE: the storage array has no reset. Resetting the pointers already
  //       empties every FIFO, and a memory without reset can map onto RAM.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ok[c]) begin
        mem_q[c][wr_ptr_q[c][AW-1:0]] <= {in_y[c*10 +: 10], in_x[c*10 +: 10],
                                          in_val[c*DATA_W +: DATA_W]};
      end
    end
  end

  assign out_val    = out_data_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign is_out_val = out_vld_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_stream_align.sv
// tb_stream_align: directed, table-driven bench for stream_align (2 channels).
// Each vector drives one cycle of inputs and states the registered output
// expected after that cycle's rising edge. Multi-cycle corners are written
// out by hand.
module tb_stream_align;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 72;
  localparam int CNT_W  = 16;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] in_val;
  logic [NUM_CH*10-1:0]     in_x;
  logic [NUM_CH*10-1:0]     in_y;
  logic [NUM_CH-1:0]        is_in_val;
  logic                     out_rdy;
  logic [NUM_CH*DATA_W-1:0] out_val;
  logic [9:0]               out_x;
  logic [9:0]               out_y;
  logic                     is_out_val;
  logic [NUM_CH-1:0]        overflow;
  logic [CNT_W-1:0]         drop_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] we;
    logic [9:0] x0, y0, x1, y1;
    logic       rdy;
    logic       ev;
    logic [9:0] ex, ey;
  } vec_t;

  vec_t vq[$];

  stream_align #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_x(in_x), .in_y(in_y), .is_in_val(is_in_val),
    .out_rdy(out_rdy),
    .out_val(out_val), .out_x(out_x), .out_y(out_y), .is_out_val(is_out_val),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Payload tags each sample with its channel and coordinate
  function automatic logic [DATA_W-1:0] pix(input int c, input logic [9:0] x, input logic [9:0] y);
    return {4'(c + 1), 28'h5A5A5A5, y, x, 20'hC3C3C};
  endfunction

  function automatic vec_t mk(input logic [1:0] we, input int x0, input int y0,
                              input int x1, input int y1, input logic rdy,
                              input logic ev, input int ex, input int ey);
    vec_t v;
    v.we = we;  v.x0 = 10'(x0); v.y0 = 10'(y0); v.x1 = 10'(x1); v.y1 = 10'(y1);
    v.rdy = rdy; v.ev = ev; v.ex = 10'(ex); v.ey = 10'(ey);
    return v;
  endfunction

  task automatic drive(input logic [1:0] we, input logic [9:0] x0, input logic [9:0] y0,
                       input logic [9:0] x1, input logic [9:0] y1, input logic rdy);
    is_in_val = we;
    in_x      = {x1, x0};
    in_y      = {y1, y0};
    in_val    = {pix(1, x1, y1), pix(0, x0, y0)};
    out_rdy   = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic ev, input logic [9:0] ex, input logic [9:0] ey);
    check({name, " valid"}, is_out_val, ev);
    if (ev) begin
      check({name, " x"}, out_x, ex);
      check({name, " y"}, out_y, ey);
      check({name, " data"}, out_val, {pix(1, ex, ey), pix(0, ex, ey)});
    end
  endtask

  task automatic run_vectors(input string tag);
    foreach (vq[i]) begin
      drive(vq[i].we, vq[i].x0, vq[i].y0, vq[i].x1, vq[i].y1, vq[i].rdy);
      tick();
      expect_out($sformatf("%s[%0d]", tag, i), vq[i].ev, vq[i].ex, vq[i].ey);
    end
    vq.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " is_out_val"}, is_out_val, 1'b0);
    check({tag, " out_val"},    out_val, '0);
    check({tag, " out_x"},      out_x, 10'd0);
    check({tag, " out_y"},      out_y, 10'd0);
    check({tag, " overflow"},   overflow, 2'b00);
    check({tag, " drop_cnt"},   drop_cnt, 16'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(tag);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  int miss_ch1[9] = '{0, 1, 2, 3, 5, 6, 7, 8, 9};

  initial begin
    reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b1);

    // Lockstep: x=0..9 on both channels, tuples after two edges, one per cycle
    do_reset("rst_lockstep");
    for (int i = 0; i < 13; i++)
      vq.push_back(mk((i < 10) ? 2'b11 : 2'b00, i, 0, i, 0, 1'b1,
                      (i >= 2 && i <= 11), i - 2, 0));
    run_vectors("lockstep");
    check("lockstep drop_cnt", drop_cnt, 16'd0);

    // Skew: ch1 trails ch0 by 5 cycles
    do_reset("rst_skew");
    for (int i = 0; i < 18; i++)
      vq.push_back(mk({(i >= 5 && i < 15), (i < 10)}, i, 0, i - 5, 0, 1'b1,
                      (i >= 7 && i <= 16), i - 7, 0));
    run_vectors("skew");
    check("skew overflow", overflow, 2'b00);
    check("skew drop_cnt", drop_cnt, 16'd0);

    // Missing pixel: ch1 never sends x=4, so ch0's x=4 is discarded
    do_reset("rst_missing");
    for (int i = 0; i < 14; i++)
      vq.push_back(mk({(i < 9), (i < 10)}, i, 0, (i < 9) ? miss_ch1[i] : 0, 0, 1'b1,
                      ((i >= 2 && i <= 5) || (i >= 7 && i <= 11)), i - 2, 0));
    run_vectors("missing");
    check("missing drop_cnt", drop_cnt, 16'd1);

    // Backpressure: hold x=0, fill both FIFOs exactly, then lose three writes
    do_reset("rst_bp");
    for (int i = 0; i < 17; i++)
      vq.push_back(mk(2'b11, i, 0, i, 0, 1'b0, (i >= 2), 0, 0));
    run_vectors("bp_fill");
    check("bp overflow at full", overflow, 2'b00);
    for (int i = 17; i < 37; i++)
      vq.push_back(mk((i < 20) ? 2'b11 : 2'b00, i, 0, i, 0, (i >= 20),
                      (i <= 35), (i < 20) ? 0 : i - 19, 0));
    run_vectors("bp_drain");
    check("bp overflow after loss", overflow, 2'b11);
    check("bp drop_cnt", drop_cnt, 16'd0);

    // Frame wrap: stale (449,374) on ch0 meets a new-frame (0,0) head on ch1
    do_reset("rst_wrap");
    drive(2'b11, 449, 374, 0, 0, 1'b1);
    tick();
    expect_out("wrap[0]", 1'b0, 0, 0);
    drive(2'b01, 0, 0, 0, 0, 1'b1);
    tick();
    expect_out("wrap[1]", 1'b0, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 1'b1);
    tick();
    expect_out("wrap[2]", 1'b0, 0, 0);
    check("wrap drop_cnt", drop_cnt, 16'd1);
    tick();
    expect_out("wrap[3]", 1'b1, 0, 0);
    tick();
    expect_out("wrap[4]", 1'b0, 0, 0);
    check("wrap drop_cnt end", drop_cnt, 16'd1);

    // Mid-stream reset: both FIFOs hold 8 entries when reset hits mid-cycle
    do_reset("rst_mid");
    for (int i = 0; i < 10; i++)
      vq.push_back(mk((i < 9) ? 2'b11 : 2'b00, i, 0, i, 0, 1'b0, (i >= 2), 0, 0));
    run_vectors("mid_fill");
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("mid_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("mid_held");
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 6; i++)
      vq.push_back(mk((i < 3) ? 2'b11 : 2'b00, 100 + i, 7, 100 + i, 7, 1'b1,
                      (i >= 2 && i <= 4), 98 + i, 7));
    run_vectors("mid_fresh");
    check("mid drop_cnt", drop_cnt, 16'd0);
    check("mid overflow", overflow, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
